seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart to the team's BCD-to-7-segment encoder.
- Watches a multiplexed 7-segment display bus (one-hot digit enables plus a shared segment bus) and reconstructs the per-digit hex/BCD values.
- Used as a self-check monitor and as a readback path for display outputs on the board.
- Qualifies each digit by dwell time, decodes the segment pattern back to 4 bits, flags illegal patterns, and pulses when a complete frame of all digits has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1).
- SEG_ACTIVE_LOW, 0, 1 = segment bus is active-low; inverted internally before decode.
- AN_ACTIVE_LOW, 0, 1 = digit enables are active-low; inverted internally before decode.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  NUM_DIGITS  digit enables; bit i selects digit i.
- seg  input  7  segment bus; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
- clr_err  input  1  synchronous clear of err_sticky.
- digits  output  4*NUM_DIGITS  captured values; digit i occupies bits [4i+3:4i].
- blank  output  NUM_DIGITS  bit i = 1 when the last capture of digit i was all-segments-off.
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err_pulse  output  1  one-cycle pulse on capture of an illegal pattern.
- err_sticky  output  1  set by err_pulse, held until clr_err or rst.

Behaviour:
- Reset values: digits=0, blank=all 1, frame_valid=0, err_pulse=0, err_sticky=0, sample regs=0, counter=0, seen mask=0.
- Input stage:
  - an and seg are polarity-normalised, then registered every cycle into s_an/s_seg.
  - Inputs are synchronous to clk; no synchroniser.
- Stability counter:
  - When the new normalised sample equals {s_an, s_seg}, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt reloads to 1.
  - Capture fires in the single cycle cnt becomes STABLE_CYCLES.
  - Inputs held constant from edge k give updated outputs visible after edge k+STABLE_CYCLES.
  - Exactly one capture per dwell; a new capture needs a change in an or seg.
- Qualification: capture is suppressed when s_an is not exactly one-hot (zero or multiple bits set). This is not an error.
- Decode (hex, abcdefg):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, 9 alternate=73.
  - A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - 00 = blank.
  - Any other pattern = illegal.
- On a legal capture for digit i:
  - digits[i] <= value; blank[i] <= 0; seen[i] <= 1.
  - If the pattern is 00: blank[i] <= 1, digits[i] unchanged, seen[i] <= 1.
- On an illegal capture:
  - digits and blank are unchanged; seen[i] is not set.
  - err_pulse=1 for one cycle; err_sticky <= 1.
- Frame completion:
  - When seen becomes all-ones, frame_valid pulses on the next cycle and seen clears.
  - If a capture coincides with the clearing cycle, that capture's bit is set in the new seen mask.
  - With NUM_DIGITS=1, every legal capture produces a frame_valid.
- Simultaneous clr_err and a new error: set wins (err_sticky=1).
- Reset mid-dwell or mid-frame: all state returns to reset values immediately. A frame in progress is discarded.

Decomposition:
- Package seg7_pkg holds:
  - Segment bit-index constants SEG_A..SEG_G.
  - Pattern constants SEG_HEX_0..SEG_HEX_F, SEG_HEX_9_ALT and SEG_BLANK.
  - A decode-result struct {legal, blank, value[3:0]}.
- The encoder and this block share the package.
- One sub-module, seg7_pattern_decode: purely combinational, 7-bit pattern in, decode-result out.
- This block is instantiated once, holding the counter, capture logic, seen mask and error logic.

Test Plan:
1. Reset, then NUM_DIGITS=4 and STABLE_CYCLES=4. Scan an=0001/seg=30, 0010/6D, 0100/79, 1000/33, each held 6 cycles -> digits=16'h4321, blank=0000, one frame_valid pulse after the 4th capture, no err.
2. Hold an=0001, seg=7E for 3 cycles, then change seg -> no capture. Hold 4 cycles -> digits[3:0]=0, capture exactly once, even if held for 20 cycles.
3. an=0011 or an=0000 with seg=7F for 10 cycles -> no capture, no err, seen unchanged.
4. an=0100, seg=0x01 for 4 cycles -> err_pulse for 1 cycle, err_sticky=1, digits unchanged. Then clr_err together with another illegal capture -> err_sticky stays 1.
5. seg=00 on digit 2 -> blank[2]=1 and seen[2] set. Same digit with seg=5F -> digits[11:8]=6, blank[2]=0. Sweep all 16 encoder patterns on digit 0 -> values 0..F recovered.
6. Assert rst after 2 of 4 digits captured -> all outputs return to reset values. Completing only the remaining 2 digits produces no frame_valid; all 4 are required.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit positions, hex glyph patterns and the decode-result record.
// Used by both the display encoder and the scan-bus decoder.
package seg7_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  function automatic logic [6:0] seg_on(input int unsigned idx);
    return 7'(1) << idx;
  endfunction

  // Glyphs are built from the segments that are lit, so each line reads like the digit's shape.
  localparam logic [6:0] SEG_HEX_0 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D)
                                   | seg_on(SEG_E) | seg_on(SEG_F);
  localparam logic [6:0] SEG_HEX_1 = seg_on(SEG_B) | seg_on(SEG_C);
  localparam logic [6:0] SEG_HEX_2 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_D) | seg_on(SEG_E)
                                   | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_3 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D)
                                   | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_4 = seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_5 = seg_on(SEG_A) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_F)
                                   | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_6 = seg_on(SEG_A) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E)
                                   | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_7 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C);
  localparam logic [6:0] SEG_HEX_8 = SEG_HEX_0 | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_9 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D)
                                   | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_9_ALT = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C)
                                       | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_A = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_E)
                                   | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_B = seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F)
                                   | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_C = seg_on(SEG_A) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F);
  localparam logic [6:0] SEG_HEX_D = seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E)
                                   | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_E = seg_on(SEG_A) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F)
                                   | seg_on(SEG_G);
  localparam logic [6:0] SEG_HEX_F = seg_on(SEG_A) | seg_on(SEG_E) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex glyph table: 7-bit abcdefg pattern to value/blank/legal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg7_dec_t  result
);

  // NOTE: every field gets a default before the case, so no path leaves result unassigned (no latch).
  always_comb begin
    result = '{legal: 1'b1, blank: 1'b0, value: 4'h0};
    case (pattern)
      SEG_HEX_0:                result.value = 4'h0;
      SEG_HEX_1:                result.value = 4'h1;
      SEG_HEX_2:                result.value = 4'h2;
      SEG_HEX_3:                result.value = 4'h3;
      SEG_HEX_4:                result.value = 4'h4;
      SEG_HEX_5:                result.value = 4'h5;
      SEG_HEX_6:                result.value = 4'h6;
      SEG_HEX_7:                result.value = 4'h7;
      SEG_HEX_8:                result.value = 4'h8;
      SEG_HEX_9, SEG_HEX_9_ALT: result.value = 4'h9;
      SEG_HEX_A:                result.value = 4'hA;
      SEG_HEX_B:                result.value = 4'hB;
      SEG_HEX_C:                result.value = 4'hC;
      SEG_HEX_D:                result.value = 4'hD;
      SEG_HEX_E:                result.value = 4'hE;
      SEG_HEX_F:                result.value = 4'hF;
      SEG_BLANK:                result.blank = 1'b1;
      default:                  result.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and rebuilds per-digit values once each digit has
// dwelt for STABLE_CYCLES samples; flags illegal glyphs and pulses on each complete frame.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_valid,
  output logic                    err_pulse,
  output logic                    err_sticky
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   s_an_d, s_an_q;
  logic [6:0]              s_seg_d, s_seg_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    fire_d, fire_q;
  logic                    same_sample;
  logic [NUM_DIGITS-1:0]   cap_mask;
  logic [4*NUM_DIGITS-1:0] digits_d, digits_q;
  logic [NUM_DIGITS-1:0]   blank_d, blank_q;
  logic [NUM_DIGITS-1:0]   seen_d, seen_q;
  logic                    err_pulse_d, err_pulse_q;
  logic                    err_sticky_d, err_sticky_q;
  seg7_dec_t               dec;

  assign an_n  = AN_ACTIVE_LOW  ? ~an  : an;
  assign seg_n = SEG_ACTIVE_LOW ? ~seg : seg;

  // fire_q marks the one cycle after cnt reaches STABLE_CYCLES, while s_an/s_seg still hold
  // the qualified sample; a held dwell saturates the counter and never re-fires.
  always_comb begin
    s_an_d      = an_n;
    s_seg_d     = seg_n;
    same_sample = (an_n == s_an_q) && (seg_n == s_seg_q);
    if (!same_sample)          cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);
    fire_d = (cnt_d == CNT_MAX) && !(same_sample && (cnt_q == CNT_MAX));
  end

  seg7_pattern_decode u_decode (
    .pattern (s_seg_q),
    .result  (dec)
  );

  always_comb begin
    cap_mask    = (fire_q && $onehot(s_an_q)) ? s_an_q : '0;
    digits_d    = digits_q;
    blank_d     = blank_q;
    seen_d      = (&seen_q) ? '0 : seen_q;
    err_pulse_d = 1'b0;
    if (|cap_mask) begin
      if (!dec.legal) begin
        err_pulse_d = 1'b1;
      end else begin
        seen_d = seen_d | cap_mask;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cap_mask[i]) begin
            blank_d[i] = dec.blank;
            if (!dec.blank) digits_d[4*i +: 4] = dec.value;
          end
        end
      end
    end
    // A new error outranks a same-cycle clear.
    err_sticky_d = err_pulse_d | (err_sticky_q & ~clr_err);
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_an_q       <= '0;
      s_seg_q      <= '0;
      cnt_q        <= '0;
      fire_q       <= 1'b0;
      digits_q     <= '0;
      blank_q      <= '1;
      seen_q       <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      s_an_q       <= s_an_d;
      s_seg_q      <= s_seg_d;
      cnt_q        <= cnt_d;
      fire_q       <= fire_d;
      digits_q     <= digits_d;
      blank_q      <= blank_d;
      seen_q       <= seen_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign frame_valid = &seen_q;
  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;

endmodule
